// File: rtl/spi_chain_master.sv
// SPI initiator for a shift/load register chain: shifts a WIDTH-bit word out MSB first,
// pulses load after the last bit and captures the chain's serial return into o_rx_data.
module spi_chain_master #(
    parameter int WIDTH   = 16,
    parameter int CLK_DIV = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_spi_miso,
    output logic             o_spi_clk,
    output logic             o_spi_dat,
    output logic             o_spi_load,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_rx_data
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LOAD,
        GAP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]   tx_sr_q, tx_sr_d;
    logic [WIDTH-1:0]   rx_sr_q, rx_sr_d;
    logic [WIDTH-1:0]   rx_data_q, rx_data_d;
    logic               spi_clk_q, spi_clk_d;
    logic               spi_dat_q, spi_dat_d;
    logic               spi_load_q, spi_load_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               miso_meta_q, miso_sync_q;
    logic               phase_end;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        spi_dat_d  = spi_dat_q;
        done_d     = 1'b0;
        phase_end  = (cnt_q == CNT_LAST);

        // Half-period counter free-runs through every active state and wraps per phase.
        if (state_q != IDLE) begin
            cnt_d = phase_end ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    tx_sr_d   = i_data;
                    bit_cnt_d = '0;
                    cnt_d     = '0;
                    spi_dat_d = i_data[WIDTH-1];
                    state_d   = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (phase_end) begin
                    state_d = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (phase_end) begin
                    rx_sr_d   = {rx_sr_q[WIDTH-2:0], miso_sync_q};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_LAST) begin
                        spi_dat_d = 1'b0;
                        state_d   = LOAD;
                    end else begin
                        // Next bit goes out on the same edge that drops spi_clk.
                        tx_sr_d   = {tx_sr_q[WIDTH-2:0], 1'b0};
                        spi_dat_d = tx_sr_q[WIDTH-2];
                        state_d   = SHIFT_LO;
                    end
                end
            end
            LOAD: begin
                if (phase_end) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (phase_end) begin
                    rx_data_d = rx_sr_q;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Pin outputs are registered copies of the next state's decode.
        spi_clk_d  = (state_d == SHIFT_HI);
        spi_load_d = (state_d == LOAD);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            rx_data_q  <= '0;
            spi_clk_q  <= 1'b0;
            spi_dat_q  <= 1'b0;
            spi_load_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_data_q  <= rx_data_d;
            spi_clk_q  <= spi_clk_d;
            spi_dat_q  <= spi_dat_d;
            spi_load_q <= spi_load_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Shift registers are fully rewritten each transfer; miso is asynchronous, hence two flops.
    always_ff @(posedge i_clk) begin
        tx_sr_q     <= tx_sr_d;
        rx_sr_q     <= rx_sr_d;
        miso_meta_q <= i_spi_miso;
        miso_sync_q <= miso_meta_q;
    end

    assign o_spi_clk  = spi_clk_q;
    assign o_spi_dat  = spi_dat_q;
    assign o_spi_load = spi_load_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_rx_data  = rx_data_q;

endmodule

// File: tb/tb_spi_chain_master.sv
// Bench for spi_chain_master: per-cycle waveform model, loopback and driven-miso readback,
// ignored starts, back-to-back transfers and mid-transfer reset.
module tb_spi_chain_master;

    localparam int W = 16;
    localparam int D = 4;
    localparam int XFER = 2 * W * D + 2 * D + 1;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] data;
    logic         miso_drv;
    logic         lb;
    logic         miso;
    logic         spi_clk, spi_dat, spi_load, busy, done;
    logic [W-1:0] rx_data;

    int           n_checks;
    int           n_fail;
    int           cyc;
    logic [W-1:0] rx_hold;

    assign miso = lb ? spi_dat : miso_drv;

    spi_chain_master #(.WIDTH(W), .CLK_DIV(D)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_data     (data),
        .i_spi_miso (miso),
        .o_spi_clk  (spi_clk),
        .o_spi_dat  (spi_dat),
        .o_spi_load (spi_load),
        .o_busy     (busy),
        .o_done     (done),
        .o_rx_data  (rx_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        logic [W-1:0] miso_word;
        bit           loop;
        logic [W-1:0] exp_rx;
    } vec_t;

    vec_t vecs[6];

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Expected {spi_clk, spi_dat, spi_load, busy, done} s cycles after the accepting edge (s=1 first).
    function automatic logic [4:0] exp_sig(input int s, input logic [W-1:0] d);
        int   ph;
        logic c, t, l, b, dn;
        c = 1'b0; t = 1'b0; l = 1'b0; b = 1'b0; dn = 1'b0;
        if (s >= 1 && s <= 2 * W * D) begin
            ph = (s - 1) / D;
            c  = ((ph % 2) == 1);
            t  = d[W - 1 - ph / 2];
            b  = 1'b1;
        end else if (s >= 1 && s <= 2 * W * D + D) begin
            l = 1'b1;
            b = 1'b1;
        end else if (s >= 1 && s <= 2 * W * D + 2 * D) begin
            b = 1'b1;
        end else if (s == XFER) begin
            dn = 1'b1;
        end
        return {c, t, l, b, dn};
    endfunction

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            check("idle_sigs", 32'({spi_clk, spi_dat, spi_load, busy, done}), 32'd0);
            check("idle_rx_hold", 32'(rx_data), 32'(rx_hold));
        end
    endtask

    task automatic run_xfer(input logic [W-1:0] d, input logic [W-1:0] mw, input bit loop,
                            input bit poke, output int done_cyc);
        logic [W-1:0] stream;
        logic [W-1:0] exp_rx;
        int           rises;
        logic         prev_clk, prev_dat, prev_load;
        lb       = loop;
        data     = d;
        start    = 1'b1;
        stream   = '0;
        rises    = 0;
        done_cyc = -1;
        exp_rx   = loop ? d : mw;
        prev_clk = spi_clk; prev_dat = spi_dat; prev_load = spi_load;
        for (int r = 0; r < XFER; r++) begin
            automatic int s = r + 1;
            if ((r % (2 * D)) == 0 && r < 2 * W * D) miso_drv = mw[W - 1 - r / (2 * D)];
            step();
            check("xfer_sigs", 32'({spi_clk, spi_dat, spi_load, busy, done}), 32'(exp_sig(s, d)));
            if (spi_clk && !prev_clk) begin
                rises++;
                stream = {stream[W-2:0], spi_dat};
                check("dat_load_stable_at_rise", 32'({spi_dat, spi_load}), 32'({prev_dat, prev_load}));
            end
            check("rx_data", 32'(rx_data), 32'((s == XFER) ? exp_rx : rx_hold));
            if (done) done_cyc = cyc;
            prev_clk = spi_clk; prev_dat = spi_dat; prev_load = spi_load;
            start = poke && (s == 10 || s == 60);
        end
        check("clk_rise_count", 32'(rises), 32'(W));
        check("bit_stream", 32'(stream), 32'(d));
        rx_hold = exp_rx;
    endtask

    initial begin
        int dc1, dc2, dc;
        n_checks = 0; n_fail = 0; cyc = 0;
        rst = 1'b1; start = 1'b0; data = '0; miso_drv = 1'b0; lb = 1'b0; rx_hold = '0;

        repeat (3) begin
            step();
            check("reset_state", 32'({spi_clk, spi_dat, spi_load, busy, done}), 32'd0);
            check("reset_rx", 32'(rx_data), 32'd0);
        end
        rst = 1'b0;
        idle_check(20);

        vecs[0] = '{16'hA5C3, 16'h3C5A, 1'b0, 16'h3C5A};
        vecs[1] = '{16'h8001, 16'h0000, 1'b1, 16'h8001};
        vecs[2] = '{16'h7FFE, 16'h0000, 1'b1, 16'h7FFE};
        for (int i = 3; i < 6; i++) begin
            vecs[i].data      = W'($urandom);
            vecs[i].miso_word = W'($urandom);
            vecs[i].loop      = 1'($urandom_range(0, 1));
            vecs[i].exp_rx    = vecs[i].loop ? vecs[i].data : vecs[i].miso_word;
        end

        for (int i = 0; i < 6; i++) begin
            run_xfer(vecs[i].data, vecs[i].miso_word, vecs[i].loop, 1'b0, dc);
            check("table_rx", 32'(rx_data), 32'(vecs[i].exp_rx));
            check("table_done_seen", 32'(dc >= 0), 32'd1);
            idle_check($urandom_range(1, 5));
        end

        // Start requests while busy must be dropped: exactly one transfer, then silence.
        run_xfer(16'h5A3C, 16'h0000, 1'b1, 1'b1, dc);
        idle_check(30);

        // Start held in the done cycle chains straight into the next transfer.
        run_xfer(16'hBEEF, 16'h0000, 1'b1, 1'b0, dc1);
        run_xfer(16'h1234, 16'h0000, 1'b1, 1'b0, dc2);
        check("b2b_done_spacing", 32'(dc2 - dc1), 32'd137);
        idle_check(2);

        // Reset at cycle 70 of a transfer aborts it cleanly.
        lb = 1'b1; data = 16'hFFFF; start = 1'b1;
        step();
        start = 1'b0;
        repeat (68) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        rx_hold = '0;
        check("rst_abort_sigs", 32'({spi_clk, spi_dat, spi_load, busy, done}), 32'd0);
        check("rst_abort_rx", 32'(rx_data), 32'd0);
        idle_check(150);
        run_xfer(16'hC0DE, 16'h0000, 1'b1, 1'b0, dc);
        check("post_rst_rx", 32'(rx_data), 32'h0000C0DE);
        idle_check(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
